fifo_reg_param: RTL and testbench

Parametrised synchronous FIFO built on a resettable, per-entry-enabled register-file array. It generalises the fixed 8×32-bit register bank into a DATA_WIDTH×DEPTH queue. The queue has wrap-around pointers, an occupancy count, full/empty and almost-full/almost-empty flags, and per-operation acknowledge/error handshakes. It sits between a producer and a consumer in the same clock domain.

---
 rtl/fifo_pkg.sv | 22 ++
 rtl/fifo_reg_param_if.sv | 39 +++
 rtl/fifo_regfile.sv | 43 ++++
 rtl/fifo_reg_param.sv | 112 +++++++++++
 tb/tb_fifo_reg_param.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised register-file FIFO.
package fifo_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_DEPTH      = 8;

  // Smallest n such that 2**n >= value (value >= 1).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Widths for the default geometry; the count carries one extra bit so it
  // can represent DEPTH itself.
  localparam int unsigned ADDR_W = clog2(DEF_DEPTH);
  localparam int unsigned CNT_W  = ADDR_W + 1;

endpackage

// File: rtl/fifo_reg_param_if.sv
// Producer/consumer handshake bundle for fifo_reg_param.
interface fifo_reg_param_if
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEF_DEPTH
);

  localparam int unsigned CW = clog2(DEPTH) + 1;

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] d_in;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] d_out;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  wr_ack;
  logic                  wr_err;
  logic                  rd_ack;
  logic                  rd_err;
  logic [CW-1:0]         data_count;

  // Producer/consumer side.
  modport master (
    output wr_en, d_in, rd_en,
    input  d_out, full, empty, almost_full, almost_empty,
           wr_ack, wr_err, rd_ack, rd_err, data_count
  );

  // FIFO side.
  modport slave (
    input  wr_en, d_in, rd_en,
    output d_out, full, empty, almost_full, almost_empty,
           wr_ack, wr_err, rd_ack, rd_err, data_count
  );

endinterface

// File: rtl/fifo_regfile.sv
// DEPTH x DATA_WIDTH storage: async-reset registers with per-entry write
// enables decoded one-hot from the write pointer, and a read mux.
module fifo_regfile
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned AW         = ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_wr_en,
  input  logic [AW-1:0]         i_wr_ptr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic [AW-1:0]         i_rd_ptr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]      w_we;

  // One-hot entry enable, only when the write is accepted.
  always_comb begin
    w_we = '0;
    if (i_wr_en) begin
      w_we = DEPTH'(1) << i_wr_ptr;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    // Each entry loads only on its own enable.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_mem[g] <= '0;
      end else if (w_we[g]) begin
        r_mem[g] <= i_wr_data;
      end
    end
  end

  assign o_rd_data = r_mem[i_rd_ptr];

endmodule

// File: rtl/fifo_reg_param.sv
// Parametrised synchronous FIFO: pointers, occupancy, flags, handshakes and
// registered read data around the fifo_regfile storage.
module fifo_reg_param
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned AF_LEVEL   = DEPTH - 1,
  parameter int unsigned AE_LEVEL   = 1
) (
  input logic             clk,
  input logic             reset_n,
  fifo_reg_param_if.slave bus
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam int unsigned CW = AW + (CNT_W - ADDR_W);

  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_wr_ack;
  logic                  r_wr_err;
  logic                  r_rd_ack;
  logic                  r_rd_err;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_rd_ok;
  logic                  w_wr_ok;

  // Flags decode only the count register, so they change cleanly per edge.
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // A full FIFO still takes a write when a read frees a slot this cycle.
  assign w_rd_ok = bus.rd_en & ~w_empty;
  assign w_wr_ok = bus.wr_en & (~w_full | w_rd_ok);

  fifo_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_regfile (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_wr_en   (w_wr_ok),
    .i_wr_ptr  (r_wr_ptr),
    .i_wr_data (bus.d_in),
    .i_rd_ptr  (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  // Pointer advance; power-of-two depth makes the wrap implicit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_ok) r_rd_ptr <= r_rd_ptr + AW'(1);
    end
  end

  // Occupancy: simultaneous accepted read and write cancel out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (w_wr_ok && !w_rd_ok) begin
      r_count <= r_count + CW'(1);
    end else if (!w_wr_ok && w_rd_ok) begin
      r_count <= r_count - CW'(1);
    end
  end

  // Registered read data, held when no read is accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dout <= '0;
    end else if (w_rd_ok) begin
      r_dout <= w_rd_data;
    end
  end

  // One-cycle acknowledge/error pulses for the previous cycle's requests.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ack <= 1'b0;
      r_wr_err <= 1'b0;
      r_rd_ack <= 1'b0;
      r_rd_err <= 1'b0;
    end else begin
      r_wr_ack <= w_wr_ok;
      r_wr_err <= bus.wr_en & ~w_wr_ok;
      r_rd_ack <= w_rd_ok;
      r_rd_err <= bus.rd_en & w_empty;
    end
  end

  assign bus.d_out        = r_dout;
  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = (32'(r_count) >= AF_LEVEL);
  assign bus.almost_empty = (32'(r_count) <= AE_LEVEL);
  assign bus.wr_ack       = r_wr_ack;
  assign bus.wr_err       = r_wr_err;
  assign bus.rd_ack       = r_rd_ack;
  assign bus.rd_err       = r_rd_err;
  assign bus.data_count   = r_count;

endmodule

// File: tb/tb_fifo_reg_param.sv
// Self-checking bench for fifo_reg_param against a queue-based model.
module tb_fifo_reg_param;
  import fifo_pkg::*;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AF    = DEPTH - 1;
  localparam int unsigned AE    = 1;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;

  always #5 clk = ~clk;

  fifo_reg_param_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  fifo_reg_param #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AF_LEVEL   (AF),
    .AE_LEVEL   (AE)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Reference model state
  logic [DW-1:0] q [$];
  logic [DW-1:0] m_dout;
  logic          m_wack, m_werr, m_rack, m_rerr;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_dout = '0;
    m_wack = 1'b0;
    m_werr = 1'b0;
    m_rack = 1'b0;
    m_rerr = 1'b0;
  endtask

  task automatic check_all(input string where);
    int sz;
    sz = q.size();
    chk({where, ".data_count"}, 64'(bus.data_count), 64'(sz));
    chk({where, ".full"},       64'(bus.full),       64'(sz == DEPTH));
    chk({where, ".empty"},      64'(bus.empty),      64'(sz == 0));
    chk({where, ".almost_full"},  64'(bus.almost_full),  64'(sz >= AF));
    chk({where, ".almost_empty"}, 64'(bus.almost_empty), 64'(sz <= AE));
    chk({where, ".d_out"},  64'(bus.d_out),  64'(m_dout));
    chk({where, ".wr_ack"}, 64'(bus.wr_ack), 64'(m_wack));
    chk({where, ".wr_err"}, 64'(bus.wr_err), 64'(m_werr));
    chk({where, ".rd_ack"}, 64'(bus.rd_ack), 64'(m_rack));
    chk({where, ".rd_err"}, 64'(bus.rd_err), 64'(m_rerr));
  endtask

  // One clock: drive on the falling edge, update the model at the rising
  // edge from the pre-edge occupancy, compare just after.
  task automatic step(input string where, input logic wr, input logic [DW-1:0] din, input logic rd);
    int sz;
    logic rok, wok;
    @(negedge clk);
    bus.wr_en = wr;
    bus.d_in  = din;
    bus.rd_en = rd;
    @(posedge clk);
    sz  = q.size();
    rok = rd && (sz != 0);
    wok = wr && ((sz < DEPTH) || rok);
    m_rack = rok;
    m_rerr = rd && (sz == 0);
    m_wack = wok;
    m_werr = wr && !wok;
    if (rok) m_dout = q.pop_front();
    if (wok) q.push_back(din);
    #1;
    check_all(where);
  endtask

  initial begin
    logic [DW-1:0] v;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.d_in  = '0;

    // Reset and idle
    #2 reset_n = 1'b0;
    model_reset();
    #10;
    check_all("reset");
    @(negedge clk);
    reset_n = 1'b1;
    step("idle", 1'b0, '0, 1'b0);
    step("idle2", 1'b0, '0, 1'b0);

    // Fill with 0x11..0x88, then one write too many
    for (int unsigned i = 1; i <= DEPTH; i++) begin
      v = DW'(i * 32'h11);
      step("fill", 1'b1, v, 1'b0);
    end
    chk("full_after_8", 64'(bus.full), 64'd1);
    chk("count_after_8", 64'(bus.data_count), 64'd8);
    step("overfill", 1'b1, 32'hDEAD_BEEF, 1'b0);
    chk("overfill_wr_err", 64'(bus.wr_err), 64'd1);

    // Drain in order (first word confirms entry 0 untouched), then underflow
    for (int unsigned i = 1; i <= DEPTH; i++) begin
      step("drain", 1'b0, '0, 1'b1);
      chk("drain_value", 64'(bus.d_out), 64'(i * 32'h11));
    end
    step("underflow", 1'b0, '0, 1'b1);
    chk("underflow_hold", 64'(bus.d_out), 64'h88);
    chk("underflow_rd_err", 64'(bus.rd_err), 64'd1);

    // Wrap-around
    for (int unsigned i = 0; i < 5; i++) step("wrap_w5", 1'b1, DW'($urandom), 1'b0);
    for (int unsigned i = 0; i < 5; i++) step("wrap_r5", 1'b0, '0, 1'b1);
    for (int unsigned i = 0; i < 6; i++) step("wrap_w6", 1'b1, DW'(32'hA0 + i), 1'b0);
    for (int unsigned i = 0; i < 6; i++) begin
      step("wrap_r6", 1'b0, '0, 1'b1);
      chk("wrap_value", 64'(bus.d_out), 64'(32'hA0 + i));
    end
    chk("wrap_count0", 64'(bus.data_count), 64'd0);

    // Simultaneous read/write when full, then when empty
    for (int unsigned i = 0; i < DEPTH; i++) step("sim_fill", 1'b1, DW'($urandom), 1'b0);
    step("sim_full", 1'b1, 32'h1234_5678, 1'b1);
    chk("sim_full_count", 64'(bus.data_count), 64'd8);
    for (int unsigned i = 0; i < DEPTH; i++) step("sim_drain", 1'b0, '0, 1'b1);
    step("sim_empty", 1'b1, 32'hCAFE_0001, 1'b1);
    chk("sim_empty_count", 64'(bus.data_count), 64'd1);
    step("sim_empty_read", 1'b0, '0, 1'b1);

    // Asynchronous reset mid-write with five words stored
    for (int unsigned i = 0; i < 5; i++) step("pre_rst", 1'b1, DW'($urandom), 1'b0);
    @(negedge clk);
    bus.wr_en = 1'b1;
    bus.d_in  = 32'h7777_7777;
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk);
    bus.wr_en = 1'b0;
    reset_n   = 1'b1;
    step("post_rst_w", 1'b1, 32'h5A, 1'b0);
    step("post_rst_r", 1'b0, '0, 1'b1);
    chk("post_rst_value", 64'(bus.d_out), 64'h5A);

    // Randomised traffic with shifting read/write bias
    for (int unsigned ph = 0; ph < 6; ph++) begin
      for (int unsigned i = 0; i < 80; i++) begin
        int unsigned wp;
        wp = (ph % 2 == 0) ? 75 : 25;
        step("random",
             $urandom_range(0, 99) < wp,
             DW'($urandom),
             $urandom_range(0, 99) < (100 - wp));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
